// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC-style control sequencer.
// Holds the FSM state encoding, control codes, opcodes and EXEC decode.
package pic_pkg;

    localparam int DEF_PC_W  = 11;
    localparam int DEF_IR_W  = 14;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_MAR,
        FETCH_PC,
        FETCH_IR,
        EXEC,
        FLUSH
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_IOR  = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_PASS = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_INC   = 2'd0,
        PC_LIT   = 2'd1,
        PC_STACK = 2'd2,
        PC_RSVD  = 2'd3
    } pc_sel_t;

    localparam logic [5:0]  OP_MOVLW  = 6'h30;
    localparam logic [5:0]  OP_ADDLW  = 6'h3E;
    localparam logic [5:0]  OP_SUBLW  = 6'h3C;
    localparam logic [5:0]  OP_ANDLW  = 6'h39;
    localparam logic [5:0]  OP_IORLW  = 6'h38;
    localparam logic [5:0]  OP_XORLW  = 6'h3A;
    localparam logic [5:0]  OP_RETLW  = 6'h34;
    localparam logic [2:0]  OP_GOTO   = 3'b101;
    localparam logic [2:0]  OP_CALL   = 3'b100;
    localparam logic [13:0] IR_RETURN = 14'h0008;
    localparam logic [13:0] IR_NOP    = 14'h0000;

    typedef struct packed {
        logic    load_w;
        logic    load_pc;
        pc_sel_t pc_sel;
        alu_op_t alu_op;
        logic    push;
        logic    pop;
        logic    illegal;
    } exec_t;

    // Map an instruction word to its EXEC-cycle actions.
    function automatic exec_t decode(input logic [DEF_IR_W-1:0] ir);
        exec_t d;
        d = '0;
        unique case (1'b1)
            (ir[13:8] == OP_MOVLW): begin
                d.load_w = 1'b1;
                d.alu_op = ALU_PASS;
            end
            (ir[13:8] == OP_ADDLW): begin
                d.load_w = 1'b1;
                d.alu_op = ALU_ADD;
            end
            (ir[13:8] == OP_SUBLW): begin
                d.load_w = 1'b1;
                d.alu_op = ALU_SUB;
            end
            (ir[13:8] == OP_ANDLW): begin
                d.load_w = 1'b1;
                d.alu_op = ALU_AND;
            end
            (ir[13:8] == OP_IORLW): begin
                d.load_w = 1'b1;
                d.alu_op = ALU_IOR;
            end
            (ir[13:8] == OP_XORLW): begin
                d.load_w = 1'b1;
                d.alu_op = ALU_XOR;
            end
            (ir[13:11] == OP_GOTO): begin
                d.load_pc = 1'b1;
                d.pc_sel  = PC_LIT;
            end
            (ir[13:11] == OP_CALL): begin
                d.load_pc = 1'b1;
                d.pc_sel  = PC_LIT;
                d.push    = 1'b1;
            end
            (ir == IR_RETURN): begin
                d.load_pc = 1'b1;
                d.pc_sel  = PC_STACK;
                d.pop     = 1'b1;
            end
            (ir[13:8] == OP_RETLW): begin
                d.load_pc = 1'b1;
                d.pc_sel  = PC_STACK;
                d.pop     = 1'b1;
                d.load_w  = 1'b1;
                d.alu_op  = ALU_PASS;
            end
            (ir == IR_NOP): begin
                d.illegal = 1'b0;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pic_seq_ctrl_if.sv
// Sequencer <-> datapath bundle: status in, load strobes and selects out.
// master is the sequencer side, slave is the datapath side.
interface pic_seq_ctrl_if
    import pic_pkg::*;
#(
    parameter int PC_W = DEF_PC_W,
    parameter int IR_W = DEF_IR_W
);

    logic            run;
    logic            rom_ack;
    logic [IR_W-1:0] ir;
    logic [PC_W-1:0] pc_value;
    logic            load_mar;
    logic            load_pc;
    logic [1:0]      pc_sel;
    logic [PC_W-1:0] stack_top;
    logic            load_ir;
    logic            rom_req;
    logic            load_w;
    logic [2:0]      alu_op;
    logic            illegal_op;
    logic            stack_ovf;
    logic            busy;

    modport master (
        input  run, rom_ack, ir, pc_value,
        output load_mar, load_pc, pc_sel,
        output stack_top, load_ir, rom_req,
        output load_w, alu_op, illegal_op,
        output stack_ovf, busy
    );

    modport slave (
        output run, rom_ack, ir, pc_value,
        input  load_mar, load_pc, pc_sel,
        input  stack_top, load_ir, rom_req,
        input  load_w, alu_op, illegal_op,
        input  stack_ovf, busy
    );

endinterface

// File: rtl/pic_ret_stack.sv
// Circular return-address stack for CALL/RETURN/RETLW.
// Overflow and underflow wrap, and latch a sticky ovf flag.
module pic_ret_stack
    import pic_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            ovf
);

    localparam int SP_W  = $clog2(DEPTH);
    localparam int CNT_W = SP_W + 1;

    logic [PC_W-1:0]  mem [DEPTH];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_prev;
    logic [CNT_W-1:0] count;

    assign sp_prev = sp - SP_W'(1);
    assign top     = mem[sp_prev];

    // Pointer, occupancy and entries move on the datapath's falling edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[sp] <= push_data;
            sp      <= sp + SP_W'(1);
            if (count == CNT_W'(DEPTH)) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            sp <= sp_prev;
            if (count == '0) begin
                ovf <= 1'b1;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pic_seq_ctrl.sv
// Fetch/execute sequencer driving every datapath load strobe.
// Adds ROM ready wait, run gating and stack-based control flow.
module pic_seq_ctrl
    import pic_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int STACK_DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    pic_seq_ctrl_if.master bus
);

    state_t          state;
    state_t          state_next;
    exec_t           dec;
    logic [IR_W-1:0] ir_cur;
    logic            in_exec;

    assign ir_cur  = bus.ir;
    assign dec     = decode(DEF_IR_W'(ir_cur));
    assign in_exec = (state == EXEC);

    pic_ret_stack #(
        .PC_W  (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (in_exec && dec.push),
        .pop       (in_exec && dec.pop),
        .push_data (bus.pc_value),
        .top       (bus.stack_top),
        .ovf       (bus.stack_ovf)
    );

    // State register, falling edge like the rest of the datapath.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: fixed fetch sequence, ROM wait and run gate.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (bus.run) state_next = FETCH_MAR;
            FETCH_MAR: state_next = FETCH_PC;
            FETCH_PC:  state_next = FETCH_IR;
            FETCH_IR:  if (bus.rom_ack) state_next = EXEC;
            EXEC:      state_next = FLUSH;
            FLUSH: begin
                if (bus.run) begin
                    state_next = FETCH_MAR;
                end else begin
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // Strobes per state; EXEC takes its actions from the decoded IR.
    always_comb begin
        bus.load_mar   = 1'b0;
        bus.load_pc    = 1'b0;
        bus.pc_sel     = PC_INC;
        bus.load_ir    = 1'b0;
        bus.rom_req    = 1'b0;
        bus.load_w     = 1'b0;
        bus.alu_op     = ALU_ADD;
        bus.illegal_op = 1'b0;
        bus.busy       = (state != IDLE);
        unique case (state)
            FETCH_MAR: bus.load_mar = 1'b1;
            FETCH_PC: begin
                bus.load_pc = 1'b1;
                bus.pc_sel  = PC_INC;
            end
            FETCH_IR: begin
                bus.rom_req = 1'b1;
                bus.load_ir = bus.rom_ack;
            end
            EXEC: begin
                bus.load_w     = dec.load_w;
                bus.alu_op     = dec.alu_op;
                bus.load_pc    = dec.load_pc;
                bus.pc_sel     = dec.pc_sel;
                bus.illegal_op = dec.illegal;
            end
            default: begin
                bus.busy = (state != IDLE);
            end
        endcase
    end

endmodule

// File: tb/tb_pic_seq_ctrl.sv
// Directed bench for pic_seq_ctrl with hand-computed expectations.
// Inputs change just after the falling edge, outputs sampled on the rising.
module tb_pic_seq_ctrl;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    pic_seq_ctrl_if bus ();

    pic_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mk(
        input logic b, input logic mar, input logic pc,
        input logic [1:0] sel, input logic ir,
        input logic req, input logic w,
        input logic [2:0] op, input logic ill);
        return {b, mar, pc, sel, ir, req, w, op, ill};
    endfunction

    function automatic logic [11:0] ctl();
        return {bus.busy, bus.load_mar, bus.load_pc,
                bus.pc_sel, bus.load_ir, bus.rom_req,
                bus.load_w, bus.alu_op, bus.illegal_op};
    endfunction

    localparam logic [11:0] K_IDLE = 12'h000;
    localparam logic [11:0] K_BUSY = 12'h800;
    localparam logic [11:0] K_MAR  = 12'hC00;
    localparam logic [11:0] K_PC   = 12'hA00;
    localparam logic [11:0] K_IR   = 12'h860;
    localparam logic [11:0] K_WAIT = 12'h820;

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.run     = 1'b0;
        bus.rom_ack = 1'b0;
        reset       = 1'b1;
        next_cyc();
        reset = 1'b0;
    endtask

    // One full instruction; returns after sampling FLUSH.
    task automatic instr(input logic [13:0] i,
                         input logic [10:0] pcv,
                         input int waits,
                         input logic [11:0] exp_exec,
                         input logic keep_run);
        bus.ir       = i;
        bus.pc_value = pcv;
        bus.run      = 1'b1;
        bus.rom_ack  = 1'b1;
        next_cyc();
        @(posedge clk);
        chk("fetch_mar", 32'(ctl()), 32'(K_MAR));
        next_cyc();
        @(posedge clk);
        chk("fetch_pc", 32'(ctl()), 32'(K_PC));
        next_cyc();
        for (int k = 0; k < waits; k++) begin
            bus.rom_ack = 1'b0;
            @(posedge clk);
            chk("rom_wait", 32'(ctl()), 32'(K_WAIT));
            next_cyc();
        end
        bus.rom_ack = 1'b1;
        @(posedge clk);
        chk("fetch_ir", 32'(ctl()), 32'(K_IR));
        next_cyc();
        bus.run = keep_run;
        @(posedge clk);
        chk("exec", 32'(ctl()), 32'(exp_exec));
        next_cyc();
        @(posedge clk);
        chk("flush", 32'(ctl()), 32'(K_BUSY));
    endtask

    logic [13:0] alu_ir [4];
    logic [2:0]  alu_op [4];
    logic [11:0] k_call;
    logic [11:0] k_ret;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.run     = 1'b0;
        bus.rom_ack = 1'b0;
        bus.ir      = '0;
        bus.pc_value = '0;
        alu_ir = '{14'h3C10, 14'h3920, 14'h3830, 14'h3A40};
        alu_op = '{3'd1, 3'd2, 3'd3, 3'd4};
        k_call = mk(1, 0, 1, 2'd1, 0, 0, 0, 3'd0, 0);
        k_ret  = mk(1, 0, 1, 2'd2, 0, 0, 0, 3'd0, 0);

        @(negedge clk);
        @(posedge clk);
        chk("rst_ctl", 32'(ctl()), 32'(K_IDLE));
        chk("rst_ovf", 32'(bus.stack_ovf), 32'd0);
        chk("rst_top", 32'(bus.stack_top), 32'd0);
        next_cyc();
        reset = 1'b0;

        instr(14'h3005, 11'h000, 0,
              mk(1, 0, 0, 2'd0, 0, 0, 1, 3'd5, 0), 1'b0);
        next_cyc();
        @(posedge clk);
        chk("idle_after", 32'(ctl()), 32'(K_IDLE));
        next_cyc();
        @(posedge clk);
        chk("idle_hold", 32'(ctl()), 32'(K_IDLE));

        instr(14'h3E10, 11'h000, 3,
              mk(1, 0, 0, 2'd0, 0, 0, 1, 3'd0, 0), 1'b1);
        for (int n = 0; n < 4; n++) begin
            instr(alu_ir[n], 11'h000, 0,
                  mk(1, 0, 0, 2'd0, 0, 0, 1, alu_op[n], 0),
                  1'b1);
        end
        instr(14'h2A55, 11'h000, 0, k_call, 1'b1);
        instr(14'h0000, 11'h000, 0, K_BUSY, 1'b0);
        next_cyc();

        do_reset();
        instr(14'h2123, 11'h011, 0, k_call, 1'b1);
        chk("call_top", 32'(bus.stack_top), 32'h011);
        chk("call_cnt", 32'(dut.u_stack.count), 32'd1);
        instr(14'h3442, 11'h124, 0,
              mk(1, 0, 1, 2'd2, 0, 0, 1, 3'd5, 0), 1'b0);
        chk("retlw_cnt", 32'(dut.u_stack.count), 32'd0);
        chk("retlw_ovf", 32'(bus.stack_ovf), 32'd0);
        next_cyc();

        do_reset();
        for (int n = 1; n <= 9; n++) begin
            instr(14'h2000 | 14'(n), 11'(n), 0, k_call, 1'b1);
            chk("push_top", 32'(bus.stack_top), 32'(n));
            if (n == 8) begin
                chk("ovf_at8", 32'(bus.stack_ovf), 32'd0);
            end
        end
        chk("ovf_at9", 32'(bus.stack_ovf), 32'd1);
        for (int r = 0; r < 8; r++) begin
            chk("pop_top", 32'(bus.stack_top), 32'(9 - r));
            instr(14'h0008, 11'h000, 0, k_ret, 1'b1);
        end
        chk("pop_cnt", 32'(dut.u_stack.count), 32'd0);

        instr(14'h1FFF, 11'h000, 0,
              mk(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 1), 1'b0);
        next_cyc();
        @(posedge clk);
        chk("run_drop", 32'(ctl()), 32'(K_IDLE));

        for (int n = 5; n <= 7; n++) begin
            instr(14'h2100, 11'(n), 0, k_call, 1'b1);
        end
        chk("pre_top", 32'(bus.stack_top), 32'h007);
        chk("pre_ovf", 32'(bus.stack_ovf), 32'd1);
        bus.ir      = 14'h0000;
        bus.rom_ack = 1'b0;
        next_cyc();
        next_cyc();
        next_cyc();
        @(posedge clk);
        chk("wait_rst", 32'(ctl()), 32'(K_WAIT));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ctl", 32'(ctl()), 32'(K_IDLE));
        chk("arst_ovf", 32'(bus.stack_ovf), 32'd0);
        chk("arst_top", 32'(bus.stack_top), 32'd0);
        chk("arst_cnt", 32'(dut.u_stack.count), 32'd0);
        next_cyc();
        @(posedge clk);
        chk("rst_hold", 32'(ctl()), 32'(K_IDLE));
        reset   = 1'b0;
        bus.run = 1'b0;

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
